// File: rtl/pmcc_code_ram_arbiter_if.sv
// Bus bundle for the PMC code RAM data-port arbiter: two master request
// channels, the write-lock control and the code RAM slave channel.
interface pmcc_code_ram_arbiter_if;
  logic        m1_wr_lock;

  logic        m0_req,    m1_req;
  logic        m0_we,     m1_we;
  logic [3:0]  m0_be,     m1_be;
  logic [31:0] m0_addr,   m1_addr;
  logic [31:0] m0_wdata,  m1_wdata;
  logic        m0_gnt,    m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata,  m1_rdata;
  logic        m0_err,    m1_err;

  logic        s_req;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_gnt;
  logic [31:0] s_rdata;

  // Arbiter side
  modport slave (
    input  m1_wr_lock,
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output s_req, s_we, s_be, s_addr, s_wdata,
    input  s_gnt, s_rdata
  );

  // Environment side: both masters plus the code RAM
  modport master (
    output m1_wr_lock,
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  s_req, s_we, s_be, s_addr, s_wdata,
    output s_gnt, s_rdata
  );
endinterface

// File: rtl/pmcc_code_ram_arbiter.sv
// Round-robin arbiter sharing the PMC code RAM data port between the host
// loader (master 0) and the PMC core data bus (master 1).

// Per-master response lane: only the owner of the registered transfer sees it.
module pmcc_cra_rsp_lane #(
  parameter int LANE = 0
) (
  input  logic        owner,
  input  logic        rvalid,
  input  logic        err,
  input  logic [31:0] rdata_in,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);
  localparam logic MY_ID = LANE[0];

  logic hit;

  assign hit      = rvalid & (owner == MY_ID);
  assign rvalid_o = hit;
  assign err_o    = hit & err;
  // Rejected transfers never touched the RAM, so their data is forced to zero
  assign rdata_o  = (hit & ~err) ? rdata_in : 32'h0;
endmodule

module pmcc_code_ram_arbiter #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pmcc_code_ram_arbiter_if.slave  bus
);
  localparam int          NUM_M       = 2;
  localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS) << 2;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } pmcc_req_t;

  pmcc_req_t [NUM_M-1:0]        mreq;
  logic      [NUM_M-1:0]        req_vec;
  logic      [NUM_M-1:0]        gnt_vec;
  logic      [NUM_M-1:0]        rvalid_vec;
  logic      [NUM_M-1:0]        err_vec;
  logic      [NUM_M-1:0][31:0]  rdata_vec;

  pmcc_req_t   cur;
  logic        any_req;
  logic        sel;
  logic [31:0] offset;
  logic        out_of_range;
  logic        locked;
  logic        rejected;
  logic        grant;

  logic owner_q,  owner_d;
  logic last_q,   last_d;
  logic rvalid_q, rvalid_d;
  logic err_q,    err_d;

  assign req_vec = {bus.m1_req, bus.m0_req};
  assign mreq[0] = '{we: bus.m0_we, be: bus.m0_be, addr: bus.m0_addr, wdata: bus.m0_wdata};
  assign mreq[1] = '{we: bus.m1_we, be: bus.m1_be, addr: bus.m1_addr, wdata: bus.m1_wdata};
  assign any_req = |req_vec;

  // Under contention the master that did not win last time goes next
  always_comb begin
    sel = 1'b0;
    if (req_vec == 2'b10)      sel = 1'b1;
    else if (req_vec == 2'b11) sel = ~last_q;
  end

  always_comb begin
    cur          = mreq[sel];
    offset       = cur.addr - BASE_ADDR;
    out_of_range = (offset >= RANGE_BYTES);
    locked       = sel & cur.we & bus.m1_wr_lock;
    rejected     = any_req & (out_of_range | locked);
    // Rejected requests complete locally without waiting for the RAM
    grant        = any_req & (bus.s_gnt | rejected);
  end

  always_comb begin
    gnt_vec = '0;
    if (grant) gnt_vec[sel] = 1'b1;
  end

  assign bus.m0_gnt  = gnt_vec[0];
  assign bus.m1_gnt  = gnt_vec[1];

  assign bus.s_req   = any_req & ~rejected;
  assign bus.s_we    = cur.we;
  assign bus.s_be    = cur.be;
  assign bus.s_addr  = offset & ~32'h3;
  assign bus.s_wdata = cur.wdata;

  always_comb begin
    owner_d  = owner_q;
    last_d   = last_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    if (grant) begin
      owner_d  = sel;
      last_d   = sel;
      rvalid_d = 1'b1;
      err_d    = rejected;
    end
  end

  // last_q resets to 1 so master 0 wins the first contention
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_M; g++) begin : g_lane
    pmcc_cra_rsp_lane #(.LANE(g)) u_lane (
      .owner    (owner_q),
      .rvalid   (rvalid_q),
      .err      (err_q),
      .rdata_in (bus.s_rdata),
      .rvalid_o (rvalid_vec[g]),
      .err_o    (err_vec[g]),
      .rdata_o  (rdata_vec[g])
    );
  end

  assign bus.m0_rvalid = rvalid_vec[0];
  assign bus.m1_rvalid = rvalid_vec[1];
  assign bus.m0_err    = err_vec[0];
  assign bus.m1_err    = err_vec[1];
  assign bus.m0_rdata  = rdata_vec[0];
  assign bus.m1_rdata  = rdata_vec[1];
endmodule

// File: tb/tb_pmcc_code_ram_arbiter.sv
// Scoreboard bench for pmcc_code_ram_arbiter: a round-robin/memory reference
// model predicts grants and responses; a negedge monitor checks responses.
module tb_pmcc_code_ram_arbiter;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmcc_code_ram_arbiter_if bus();

  pmcc_code_ram_arbiter #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          v;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          due;
    int          owner;
    bit          err;
    bit          chk_data;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  txn_t        pend[2];
  logic [31:0] ref_mem [int];
  int          last_m = 1;
  bit          lock   = 1'b0;
  bit          sgnt   = 1'b1;
  bit          mon_en = 1'b0;
  int          cyc    = 0;
  int          nchk   = 0;
  int          nfail  = 0;
  int          gnt_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Code RAM: grants in the request cycle, read data one cycle later
  bit          ram_init = 1'b0;
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
      ram_init <= 1'b1;
    end else if (bus.s_req && bus.s_gnt) begin
      if (bus.s_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.s_be[b]) ram[bus.s_addr[11:2]][b*8 +: 8] <= bus.s_wdata[b*8 +: 8];
      end else begin
        bus.s_rdata <= ram[bus.s_addr[11:2]];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] off);
    int key = int'(off[31:2]);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  task automatic set_req(input int m, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    pend[m] = '{v: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
  endtask

  // One bus cycle: drive after posedge, predict and compare at negedge
  task automatic step(input bit rst_low);
    bit          any, rej, g;
    int          sel;
    logic [31:0] off, cur;
    @(posedge clk); #1;
    rst_n          = ~rst_low;
    bus.m0_req     = pend[0].v; bus.m0_we = pend[0].we; bus.m0_be = pend[0].be;
    bus.m0_addr    = pend[0].addr; bus.m0_wdata = pend[0].wdata;
    bus.m1_req     = pend[1].v; bus.m1_we = pend[1].we; bus.m1_be = pend[1].be;
    bus.m1_addr    = pend[1].addr; bus.m1_wdata = pend[1].wdata;
    bus.m1_wr_lock = lock;
    bus.s_gnt      = sgnt;
    @(negedge clk);
    any = pend[0].v || pend[1].v;
    sel = (pend[0].v && pend[1].v) ? 1 - last_m : (pend[1].v ? 1 : 0);
    off = pend[sel].addr - BASE;
    rej = any && ((off >= DEPTH * 4) || (sel == 1 && pend[1].we && lock));
    g   = any && (sgnt || rej);
    check("gnt", {bus.m1_gnt, bus.m0_gnt}, g ? (sel == 1 ? 2'b10 : 2'b01) : 2'b00);
    check("s_req", bus.s_req, any && !rej);
    if (any && !rej) begin
      check("s_addr_wdata", {bus.s_addr, bus.s_wdata}, {off & ~32'h3, pend[sel].wdata});
      check("s_we_be", {bus.s_we, bus.s_be}, {pend[sel].we, pend[sel].be});
    end
    gnt_log.push_back(bus.m1_gnt ? 1 : (bus.m0_gnt ? 0 : -1));
    if (g) begin
      if (!rst_low) begin
        exp_q.push_back('{due: cyc + 1, owner: sel, err: rej,
                          chk_data: rej || !pend[sel].we,
                          data: rej ? 32'h0 : ref_rd(off)});
        if (!rej && pend[sel].we) begin
          cur = ref_rd(off);
          for (int b = 0; b < 4; b++)
            if (pend[sel].be[b]) cur[b*8 +: 8] = pend[sel].wdata[b*8 +: 8];
          ref_mem[int'(off[31:2])] = cur;
        end
        last_m = sel;
      end
      pend[sel].v = 1'b0;
    end
    if (rst_low) last_m = 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend[0].v || pend[1].v) && n < 50) begin
      step(1'b0);
      n++;
    end
    check("idle_timeout", {pend[1].v, pend[0].v}, 2'b00);
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
    step(1'b0);
    step(1'b0);
  endtask

  // Response monitor
  always @(negedge clk) begin : mon
    rsp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("rvalid_route", {bus.m1_rvalid, bus.m0_rvalid}, e.owner == 1 ? 2'b10 : 2'b01);
        check("err", e.owner == 1 ? bus.m1_err : bus.m0_err, e.err);
        if (e.chk_data)
          check("rdata", e.owner == 1 ? bus.m1_rdata : bus.m0_rdata, e.data);
        check("nonowner_quiet",
              e.owner == 1 ? {bus.m0_err, bus.m0_rdata} : {bus.m1_err, bus.m1_rdata}, 33'h0);
      end else begin
        check("no_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pend[0] = '{v: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0};
    pend[1] = pend[0];
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.m1_wr_lock = 1'b0; bus.s_gnt = 1'b1;
    bus.m0_we = 1'b0; bus.m1_we = 1'b0; bus.m0_be = '0; bus.m1_be = '0;
    bus.m0_addr = '0; bus.m1_addr = '0; bus.m0_wdata = '0; bus.m1_wdata = '0;

    repeat (3) step(1'b1);
    mon_en = 1'b1;
    check("rst_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
    check("rst_rdata", {bus.m1_rdata, bus.m0_rdata}, 64'h0);
    check("rst_err_sreq", {bus.m1_err, bus.m0_err, bus.s_req}, 3'b000);

    // Host write then read back
    set_req(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF); wait_idle();
    set_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);        wait_idle();

    // Continuous contention right after reset: strict alternation, m0 first
    step(1'b1);
    gnt_log.delete();
    set_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    set_req(1, 1'b0, BASE + 32'h14, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      if (!pend[0].v) set_req(0, 1'b0, BASE + 32'h10 + 32'(i * 8), 32'h0, 4'hF);
      if (!pend[1].v) set_req(1, 1'b0, BASE + 32'h14 + 32'(i * 8), 32'h0, 4'hF);
    end
    for (int i = 0; i < 6; i++) check("rr_order", 64'(gnt_log[i]), 64'(i % 2));
    wait_idle();

    // Out-of-range read by m1
    set_req(1, 1'b0, BASE + 32'h1000, 32'h0, 4'hF); wait_idle();

    // Locked m1 write is rejected and leaves the RAM untouched
    set_req(0, 1'b1, BASE + 32'h20, 32'h12345678, 4'hF); wait_idle();
    lock = 1'b1;
    set_req(1, 1'b1, BASE + 32'h20, 32'hBAD0BAD0, 4'hF); wait_idle();
    set_req(0, 1'b0, BASE + 32'h20, 32'h0, 4'hF);        wait_idle();
    set_req(1, 1'b0, BASE + 32'h20, 32'h0, 4'hF);        wait_idle();
    lock = 1'b0;

    // Below-base address wraps and is rejected; in-range offset forwards
    set_req(0, 1'b0, 32'h0000_FFFC, 32'h0, 4'hF); wait_idle();
    set_req(0, 1'b0, BASE + 32'h4, 32'h0, 4'hF);  wait_idle();

    // Reset during the grant cycle drops the response; m0 wins afterwards
    set_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    step(1'b1);
    check("rst_drop_pending", pend[0].v, 1'b0);
    gnt_log.delete();
    set_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    set_req(1, 1'b0, BASE + 32'h20, 32'h0, 4'hF);
    step(1'b0);
    check("post_rst_first", 64'(gnt_log[0]), 64'd0);
    wait_idle();

    // Randomized traffic with RAM stalls and lock toggling
    for (int it = 0; it < 400; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m].v && $urandom_range(0, 1) == 1) begin
          logic [31:0] a;
          case ($urandom_range(0, 7))
            0:       a = BASE + 32'h1000 + 32'($urandom_range(0, 255) * 4);
            1:       a = BASE - 32'($urandom_range(1, 16) * 4);
            default: a = BASE + 32'($urandom_range(0, 31) * 4);
          endcase
          set_req(m, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(1, 15)));
        end
      end
      if ($urandom_range(0, 15) == 0) lock = ~lock;
      sgnt = ($urandom_range(0, 3) != 0);
      step(1'b0);
    end
    sgnt = 1'b1;
    wait_idle();

    repeat (3) step(1'b0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
